ctl_arb: RTL and testbench
==========================

Name: ctl_arb

Overview:
- Synchronous round-robin arbiter sharing one downstream four-phase req/ack handshake channel among N_REQ upstream four-phase channels.
- Sits in front of a shared pipeline stage controller and its bundled data register.
- Drives a one-hot select (plus index) that steers the data mux, held stable for the whole downstream handshake.
- All handshake inputs are treated as asynchronous and are synchronised internally.

Parameters:
- N_REQ, 4, number of upstream requesters (2..16).
- SYNC_STAGES, 2, flip-flop stages on every async handshake input (>=2).
- TIMEOUT_CYCLES, 1024, watchdog limit in REQ state (used only with CTL_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_up_i  in  N_REQ  upstream requests, one per requester, async.
- ack_up_o  out  N_REQ  upstream acknowledges, registered.
- req_dn_o  out  1  downstream request, registered.
- ack_dn_i  in  1  downstream acknowledge, async.
- sel_o  out  N_REQ  one-hot grant for the data mux, registered.
- sel_idx_o  out  $clog2(N_REQ)  binary index of the current grant.
- busy_o  out  1  high whenever state != IDLE.
- err_o  out  1  sticky watchdog error; tied to 0 without the optional feature.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs go to 0. State = IDLE.
  - Round-robin pointer last = N_REQ-1, so requester 0 has top priority on the first arbitration.
  - Synchronisers clear to 0.
- Synchronised signals: rq[i] and ak are req_up_i[i] and ack_dn_i after SYNC_STAGES flops.
- FSM states: IDLE, REQ, ACK, RTZ.
- IDLE:
  - Grants only if ak==0 and any rq[i]==1. This also covers reset mid-handshake: no new grant until the downstream ack has returned to zero.
  - Winner is the first set rq scanning from last+1 upward, wrapping at N_REQ.
  - On the same edge: sel_o/sel_idx_o load the winner, last is updated to the winner, req_dn_o<=1, state -> REQ.
- REQ:
  - Holds req_dn_o=1.
  - When ak==1: ack_up_o[g]<=1, state -> ACK.
  - If rq[g] drops early (protocol violation), it is ignored and the grant is held.
- ACK: when rq[g]==0: req_dn_o<=0, state -> RTZ. ack_up_o[g] stays 1.
- RTZ: when ak==0: ack_up_o[g]<=0, sel_o<=0, state -> IDLE.
- Invariants:
  - ack_up_o is only ever asserted for the granted index.
  - sel_o is constant from the REQ entry edge until the RTZ exit edge, which satisfies the bundled-data constraint.
  - Requests arriving during a handshake wait. Each requester is served at most once per N_REQ grants when all are requesting.
- Latency:
  - req_up_i rise to req_dn_o rise: SYNC_STAGES+1 edges (3 at default).
  - ack_dn_i rise to ack_up_o rise: SYNC_STAGES+1 edges.
  - Minimum full cycle: 4*(SYNC_STAGES+1) edges.
  - At most one grant per IDLE visit; IDLE always lasts at least 1 cycle between handshakes.
- Simultaneous requests: resolved by the round-robin order only. There is no fixed priority apart from the post-reset start point.

Optional Feature:
- Macro: CTL_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in REQ and clears on REQ entry.
  - At TIMEOUT_CYCLES with ak still 0: err_o<=1 (sticky until rst_i), req_dn_o<=0, sel_o<=0, ack_up_o untouched (stays 0), state -> IDLE.
  - The pointer has already advanced, so other requesters are served next.
- Undefined: no counter is present, err_o is constant 0, and REQ waits indefinitely.

Decomposition:
- ctl_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} ctl_arb_state_t;
  - the default constants CTL_SYNC_STAGES=2 and CTL_TIMEOUT_DEF=1024.
- One sub-module, ctl_sync: parameterised width × SYNC_STAGES flop chain with async active-high clear. Instantiated once for req_up_i (width N_REQ) and once for ack_dn_i (width 1).

Test Plan:
- Reset, then single requester: rst_i 1->0; req_up_i=4'b0100.
  - req_dn_o rises 3 edges later with sel_o=4'b0100 and sel_idx_o=2.
  - ack_dn_i=1 -> ack_up_o=4'b0100 after 3 edges.
  - Drop req_up_i, then ack_dn_i -> all outputs return to 0 and busy_o=0.
- Round-robin fairness: hold req_up_i=4'b1111 and complete 8 handshakes. Grant order must be 0,1,2,3,0,1,2,3.
- Late arrival: during grant 1 (sel_idx_o=1), raise req 0 and req 3. The next grant is 3, then 0.
- Reset mid-handshake: assert rst_i in ACK with ack_dn_i=1 held.
  - Outputs go to 0 immediately.
  - After release with req_up_i=4'b0001, no req_dn_o occurs until ack_dn_i goes to 0.
- Protocol violation: drop req_up_i[g] while in REQ. req_dn_o and sel_o are held. The cycle completes normally once ack arrives.
- CTL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: request with ack_dn_i stuck at 0.
  - err_o=1 and req_dn_o=0 after 16 REQ cycles.
  - A second requester is then granted.
  - err_o stays 1 until rst_i.

Source files
------------

// File: rtl/ctl_pkg.sv
// Shared types and default constants for the ctl_arb handshake arbiter.
package ctl_pkg;

  typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} ctl_arb_state_t;

  localparam int CTL_SYNC_STAGES = 2;
  localparam int CTL_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/ctl_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous handshake levels.
// Each bit is an independent level signal, so no bus coherency is assumed.
module ctl_sync
  import ctl_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = CTL_SYNC_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/ctl_arb.sv
// Round-robin arbiter multiplexing N_REQ four-phase req/ack channels onto one.
// Optional REQ-state watchdog enabled by defining CTL_ARB_TIMEOUT_EN.
module ctl_arb
  import ctl_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int SYNC_STAGES    = CTL_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = CTL_TIMEOUT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_up_i,
  output logic [N_REQ-1:0]         ack_up_o,
  output logic                     req_dn_o,
  input  logic                     ack_dn_i,
  output logic [N_REQ-1:0]         sel_o,
  output logic [$clog2(N_REQ)-1:0] sel_idx_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int                 IDX_W   = $clog2(N_REQ);
  localparam logic [IDX_W:0]     N_REQ_W = (IDX_W+1)'(N_REQ);
  localparam logic [N_REQ-1:0]   ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("ctl_arb: N_REQ must be in 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ctl_arb: SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ctl_arb: TIMEOUT_CYCLES must be >= 1");
  end

  logic [N_REQ-1:0] rq;
  logic             ak;

  ctl_sync #(.WIDTH(N_REQ), .STAGES(SYNC_STAGES)) u_sync_req (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (req_up_i),
    .q_o   (rq)
  );

  ctl_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ack (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ack_dn_i),
    .q_o   (ak)
  );

  ctl_arb_state_t   state_q, state_d;
  logic [N_REQ-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] ack_up_q, ack_up_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             req_dn_q, req_dn_d;
  logic             rq_g;

  // Round-robin scan starting just after the previous winner, wrapping at N_REQ.
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k + 1);
      if (cand >= N_REQ_W) begin
        cand = cand - N_REQ_W;
      end
      if (!win_vld && rq[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign rq_g = |(rq & sel_q);

`ifdef CTL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    last_d   = last_q;
    ack_up_d = ack_up_q;
    req_dn_d = req_dn_q;
`ifdef CTL_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      // A stale downstream ack (e.g. after reset mid-handshake) blocks new grants.
      IDLE: begin
        if (!ak && win_vld) begin
          sel_d    = ONE_HOT << win_idx;
          idx_d    = win_idx;
          last_d   = win_idx;
          req_dn_d = 1'b1;
          state_d  = REQ;
`ifdef CTL_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      REQ: begin
        if (ak) begin
          ack_up_d = sel_q;
          state_d  = ACK;
        end
`ifdef CTL_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          req_dn_d = 1'b0;
          sel_d    = '0;
          idx_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ACK: begin
        if (!rq_g) begin
          req_dn_d = 1'b0;
          state_d  = RTZ;
        end
      end
      RTZ: begin
        if (!ak) begin
          ack_up_d = '0;
          sel_d    = '0;
          idx_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      ack_up_q <= '0;
      req_dn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      ack_up_q <= ack_up_d;
      req_dn_q <= req_dn_d;
    end
  end

`ifdef CTL_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ack_up_o  = ack_up_q;
  assign req_dn_o  = req_dn_q;
  assign sel_o     = sel_q;
  assign sel_idx_o = idx_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_ctl_arb.sv
// Scoreboard bench for ctl_arb: expected grant order is queued by the stimulus
// and popped by a monitor on every downstream request rise.
module tb_ctl_arb;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_up;
  logic [N-1:0] ack_up;
  logic [N-1:0] sel;
  logic [1:0]   sel_idx;
  logic         req_dn;
  logic         ack_dn;
  logic         busy;
  logic         err;

  logic [N-1:0] up_man;
  logic [N-1:0] up_agent;
  logic         up_auto;
  logic         dn_man;
  logic         dn_agent;
  logic         dn_auto;

  assign req_up = up_auto ? up_agent : up_man;
  assign ack_dn = dn_auto ? dn_agent : dn_man;

  ctl_arb #(.N_REQ(N), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_up_i  (req_up),
    .ack_up_o  (ack_up),
    .req_dn_o  (req_dn),
    .ack_dn_i  (ack_dn),
    .sel_o     (sel),
    .sel_idx_o (sel_idx),
    .busy_o    (busy),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int done_cnt[N];
  int target[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_dn"}, 32'(req_dn), 32'd0);
    chk({tag, "_ack_up"}, 32'(ack_up), 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_sel_idx"}, 32'(sel_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // which: 0 = req_dn, 1 = any ack_up, 2 = busy
  task automatic wait_cond(input string name, input int which, input logic val);
    int   n;
    logic cur;
    cur = 1'b0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      case (which)
        0:       cur = req_dn;
        1:       cur = |ack_up;
        default: cur = busy;
      endcase
      if (cur == val) break;
    end
    checks++;
    if (n == 300) begin
      errors++;
      $display("FAIL wait_%s actual=%0b required=%0b", name, cur, val);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Upstream agent: full four-phase handshakes until done_cnt reaches target.
  initial begin
    up_agent = '0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (up_agent[i] && ack_up[i]) begin
          up_agent[i] = 1'b0;
          done_cnt[i]++;
        end else if (up_auto && !up_agent[i] && !ack_up[i] && done_cnt[i] < target[i]) begin
          up_agent[i] = 1'b1;
        end
      end
    end
  end

  // Downstream agent: ack simply follows req.
  initial begin
    dn_agent = 1'b0;
    forever begin
      @(negedge clk);
      dn_agent = req_dn;
    end
  end

  // Monitor: pop expected grant on each req_dn rise; check ack steering on each ack rise.
  initial begin
    logic         prev_req;
    logic [N-1:0] prev_ack;
    logic [N-1:0] cur_oh;
    int           e;
    prev_req = 1'b0;
    prev_ack = '0;
    cur_oh   = '0;
    forever begin
      @(negedge clk);
      if (req_dn && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected actual_idx=%0d required=none", sel_idx);
        end else begin
          e = exp_q.pop_front();
          cur_oh = 4'b0001 << e;
          chk("grant_sel", 32'(sel), 32'(cur_oh));
          chk("grant_idx", 32'(sel_idx), 32'(e));
        end
      end
      if (ack_up != '0 && prev_ack == '0) begin
        chk("ack_up_steer", 32'(ack_up), 32'(cur_oh));
      end
      prev_req = req_dn;
      prev_ack = ack_up;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    rst     = 1'b1;
    up_man  = '0;
    dn_man  = 1'b0;
    up_auto = 1'b0;
    dn_auto = 1'b0;
    for (int i = 0; i < N; i++) target[i] = 0;

    // Reset state and single-requester latency
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    up_man = 4'b0100;
    exp_q.push_back(2);
    repeat (2) @(negedge clk);
    chk("req_lat_early", 32'(req_dn), 32'd0);
    @(negedge clk);
    chk("req_lat_edge3", 32'(req_dn), 32'd1);
    dn_man = 1'b1;
    repeat (2) @(negedge clk);
    chk("ack_lat_early", 32'(ack_up), 32'd0);
    @(negedge clk);
    chk("ack_lat_edge3", 32'(ack_up), 32'b0100);
    up_man = '0;
    wait_cond("single_rtz", 0, 1'b0);
    dn_man = 1'b0;
    wait_cond("single_idle", 2, 1'b0);
    chk_idle("single_end");

    // Round-robin fairness from reset
    do_reset();
    for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
    for (int i = 0; i < N; i++) target[i] = done_cnt[i] + 2;
    up_auto = 1'b1;
    dn_auto = 1'b1;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done_cnt[0] == target[0] && done_cnt[1] == target[1] &&
          done_cnt[2] == target[2] && done_cnt[3] == target[3]) break;
    end
    chk("rr_complete", 32'(n < 2000), 32'd1);
    wait_cond("rr_idle", 2, 1'b0);

    // Late arrivals during grant 1
    exp_q.push_back(1);
    target[1] = done_cnt[1] + 1;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_dn && sel_idx == 2'd1) break;
    end
    chk("late_grant1_seen", 32'(n < 300), 32'd1);
    exp_q.push_back(3);
    exp_q.push_back(0);
    target[0] = done_cnt[0] + 1;
    target[3] = done_cnt[3] + 1;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done_cnt[0] == target[0] && done_cnt[3] == target[3] &&
          done_cnt[1] == target[1]) break;
    end
    chk("late_complete", 32'(n < 1000), 32'd1);
    wait_cond("late_idle", 2, 1'b0);
    @(negedge clk);
    up_auto = 1'b0;
    dn_auto = 1'b0;

    // Reset in ACK with downstream ack held high
    up_man = 4'b0001;
    exp_q.push_back(0);
    wait_cond("mid_req", 0, 1'b1);
    dn_man = 1'b1;
    wait_cond("mid_ack", 1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(0);
    repeat (10) @(negedge clk);
    chk("mid_no_grant", 32'(req_dn), 32'd0);
    dn_man = 1'b0;
    wait_cond("mid_regrant", 0, 1'b1);
    dn_man = 1'b1;
    wait_cond("mid_ack2", 1, 1'b1);
    up_man = '0;
    wait_cond("mid_rtz", 0, 1'b0);
    dn_man = 1'b0;
    wait_cond("mid_idle", 2, 1'b0);
    chk_idle("mid_end");

    // Early request drop while in REQ
    up_man = 4'b0010;
    exp_q.push_back(1);
    wait_cond("viol_req", 0, 1'b1);
    up_man = '0;
    repeat (6) @(negedge clk);
    chk("viol_req_held", 32'(req_dn), 32'd1);
    chk("viol_sel_held", 32'(sel), 32'b0010);
    dn_man = 1'b1;
    wait_cond("viol_ack", 1, 1'b1);
    wait_cond("viol_rtz", 0, 1'b0);
    dn_man = 1'b0;
    wait_cond("viol_idle", 2, 1'b0);
    chk_idle("viol_end");

`ifdef CTL_ARB_TIMEOUT_EN
    // Watchdog with downstream ack stuck low
    up_man = 4'b0100;
    exp_q.push_back(2);
    wait_cond("to_req", 0, 1'b1);
    up_man = 4'b0101;
    exp_q.push_back(0);
    repeat (15) @(negedge clk);
    chk("to_req_before", 32'(req_dn), 32'd1);
    chk("to_err_before", 32'(err), 32'd0);
    @(negedge clk);
    chk("to_req_after", 32'(req_dn), 32'd0);
    chk("to_err_after", 32'(err), 32'd1);
    chk("to_ack_untouched", 32'(ack_up), 32'd0);
    wait_cond("to_regrant", 0, 1'b1);
    up_man = 4'b0001;
    dn_man = 1'b1;
    wait_cond("to_ack", 1, 1'b1);
    chk("to_err_sticky", 32'(err), 32'd1);
    up_man = '0;
    wait_cond("to_rtz", 0, 1'b0);
    dn_man = 1'b0;
    wait_cond("to_idle", 2, 1'b0);
    chk("to_err_sticky2", 32'(err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("to_err_cleared", 32'(err), 32'd0);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
